// File: rtl/rcv_fifo_ptrs.sv
// Receive FIFO storage and head/tail pointer management (4 entries, FWFT read).
// Optional occupancy counter port `count` is enabled with macro RCV_FIFO_COUNT_EN.
module rcv_fifo_ptrs #(
   parameter int DATA_WIDTH = 8,
   parameter int SIDE_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [SIDE_WIDTH-1:0] wr_side,
   input  logic                  rd_en,
   input  logic                  clr_err,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [1:0]            head_ptr,
   output logic [1:0]            tail_ptr,
   output logic                  head_tog,
   output logic                  tail_tog,
   output logic [SIDE_WIDTH-1:0] tail_side,
   output logic                  overflow,
`ifdef RCV_FIFO_COUNT_EN
   output logic [2:0]            count,
`endif
   output logic                  underflow
);

   localparam int EW = DATA_WIDTH + SIDE_WIDTH;

   logic [EW-1:0] mem_q [4];
   logic [1:0]    head_q, head_d, tail_q, tail_d;
   logic          head_tog_q, head_tog_d, tail_tog_q, tail_tog_d;
   logic          ovf_q, ovf_d, unf_q, unf_d;
   logic          empty, full, wr_acc, rd_acc;

   // Pointers equal: the toggle bits tell a full lap apart from no data at all.
   assign empty  = (head_q == tail_q) && (head_tog_q == tail_tog_q);
   assign full   = (head_q == tail_q) && (head_tog_q != tail_tog_q);
   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   always_comb begin
      head_d     = head_q;
      head_tog_d = head_tog_q;
      tail_d     = tail_q;
      tail_tog_d = tail_tog_q;
      if (wr_acc) begin
         head_d     = head_q + 2'd1;
         head_tog_d = head_tog_q ^ (head_q == 2'd3);
      end
      if (rd_acc) begin
         tail_d     = tail_q + 2'd1;
         tail_tog_d = tail_tog_q ^ (tail_q == 2'd3);
      end
      // A new error event outranks a clear in the same cycle.
      ovf_d = (clr_err ? 1'b0 : ovf_q) | (wr_en && full);
      unf_d = (clr_err ? 1'b0 : unf_q) | (rd_en && empty);
   end

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[head_q] <= {wr_side, wr_data};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q     <= 2'd0;
         tail_q     <= 2'd0;
         head_tog_q <= 1'b0;
         tail_tog_q <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         head_tog_q <= head_tog_d;
         tail_tog_q <= tail_tog_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

`ifdef RCV_FIFO_COUNT_EN
   logic [2:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (wr_acc && !rd_acc) begin
         count_d = count_q + 3'd1;
      end else if (rd_acc && !wr_acc) begin
         count_d = count_q - 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 3'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
`endif

   // Empty forces zeros so stale storage never reaches the framing-error decode.
   assign rd_data   = empty ? '0 : mem_q[tail_q][DATA_WIDTH-1:0];
   assign tail_side = empty ? '0 : mem_q[tail_q][EW-1:DATA_WIDTH];
   assign head_ptr  = head_q;
   assign tail_ptr  = tail_q;
   assign head_tog  = head_tog_q;
   assign tail_tog  = tail_tog_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule

// File: tb/tb_rcv_fifo_ptrs.sv
// Self-checking bench for rcv_fifo_ptrs: directed plan followed by random traffic
// against a queue-based model. Checks `count` too when RCV_FIFO_COUNT_EN is defined.
module tb_rcv_fifo_ptrs;

   localparam int DW = 8;
   localparam int SW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic [SW-1:0] wr_side = '0;
   logic          rd_en = 1'b0;
   logic          clr_err = 1'b0;
   logic [DW-1:0] rd_data;
   logic [1:0]    head_ptr, tail_ptr;
   logic          head_tog, tail_tog;
   logic [SW-1:0] tail_side;
   logic          overflow, underflow;
`ifdef RCV_FIFO_COUNT_EN
   logic [2:0]    count;
`endif

   rcv_fifo_ptrs #(.DATA_WIDTH(DW), .SIDE_WIDTH(SW)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .wr_side   (wr_side),
      .rd_en     (rd_en),
      .clr_err   (clr_err),
      .rd_data   (rd_data),
      .head_ptr  (head_ptr),
      .tail_ptr  (tail_ptr),
      .head_tog  (head_tog),
      .tail_tog  (tail_tog),
      .tail_side (tail_side),
      .overflow  (overflow),
`ifdef RCV_FIFO_COUNT_EN
      .count     (count),
`endif
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   // Model: FIFO contents as a queue, pointers as lifetime write/read totals.
   logic [SW+DW-1:0] mq[$];
   int unsigned      n_wr = 0;
   int unsigned      n_rd = 0;
   logic             m_ovf = 1'b0;
   logic             m_unf = 1'b0;
   int               checks = 0;
   int               passed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic check_all(input string step);
      logic [SW+DW-1:0] head_e;
      head_e = (mq.size() == 0) ? '0 : mq[0];
      check({step, ":head_ptr"},  32'(head_ptr),  32'(n_wr % 4));
      check({step, ":head_tog"},  32'(head_tog),  32'((n_wr / 4) % 2));
      check({step, ":tail_ptr"},  32'(tail_ptr),  32'(n_rd % 4));
      check({step, ":tail_tog"},  32'(tail_tog),  32'((n_rd / 4) % 2));
      check({step, ":rd_data"},   32'(rd_data),   32'(head_e[DW-1:0]));
      check({step, ":tail_side"}, 32'(tail_side), 32'(head_e[SW+DW-1:DW]));
      check({step, ":overflow"},  32'(overflow),  32'(m_ovf));
      check({step, ":underflow"}, 32'(underflow), 32'(m_unf));
`ifdef RCV_FIFO_COUNT_EN
      check({step, ":count"},     32'(count),     32'(mq.size()));
`endif
   endtask

   // One clock: apply inputs, advance the model on the edge, check 1 time unit later.
   task automatic cyc(input string step, input logic w, input logic [DW-1:0] d,
                      input logic [SW-1:0] s, input logic r, input logic c, input logic rs);
      logic was_full, was_empty;
      wr_en = w; wr_data = d; wr_side = s; rd_en = r; clr_err = c; rst = rs;
      @(posedge clk);
      was_full  = (mq.size() == 4);
      was_empty = (mq.size() == 0);
      if (rs) begin
         mq.delete();
         n_wr = 0; n_rd = 0; m_ovf = 1'b0; m_unf = 1'b0;
      end else begin
         m_ovf = (c ? 1'b0 : m_ovf) | (w && was_full);
         m_unf = (c ? 1'b0 : m_unf) | (r && was_empty);
         if (r && !was_empty) begin
            void'(mq.pop_front());
            n_rd++;
         end
         if (w && !was_full) begin
            mq.push_back({s, d});
            n_wr++;
         end
      end
      #1;
      wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; rst = 1'b0;
      check_all(step);
      $display("%s: wr=%0b d=%02h s=%0b rd=%0b clr=%0b rst=%0b -> hp=%0d ht=%0b tp=%0d tt=%0b rd_data=%02h side=%0b ovf=%0b unf=%0b",
               step, w, d, s, r, c, rs, head_ptr, head_tog, tail_ptr, tail_tog,
               rd_data, tail_side, overflow, underflow);
   endtask

   initial begin
      logic [DW-1:0] seq [4];
      seq[0] = 8'hA1; seq[1] = 8'hB2; seq[2] = 8'hC3; seq[3] = 8'hD4;

      // 1: reset then idle
      cyc("reset", 0, 8'h00, 2'b00, 0, 0, 1);
      cyc("idle",  0, 8'h00, 2'b00, 0, 0, 0);
      check("idle_rd_data_zero", 32'(rd_data), 32'h0);

      // 2: fill to full, then a dropped fifth write
      for (int i = 0; i < 4; i++) cyc("fill", 1, seq[i], 2'b00, 0, 0, 0);
      check("full_head_tog", 32'(head_tog), 32'h1);
      cyc("over", 1, 8'hE5, 2'b00, 0, 0, 0);
      check("over_flag", 32'(overflow), 32'h1);
      check("over_rd_data", 32'(rd_data), 32'hA1);

      // 3: side-band on a single entry
      cyc("reset", 0, 8'h00, 2'b00, 0, 0, 1);
      cyc("side_wr", 1, 8'h55, 2'b01, 0, 0, 0);
      check("side_visible", 32'(tail_side), 32'h1);
      cyc("side_pop", 0, 8'h00, 2'b00, 1, 0, 0);
      check("side_cleared", 32'(tail_side), 32'h0);

      // 4: steady-state push/pop at occupancy 2 across pointer wraps
      cyc("reset", 0, 8'h00, 2'b00, 0, 0, 1);
      cyc("pre", 1, 8'h10, 2'b00, 0, 0, 0);
      cyc("pre", 1, 8'h11, 2'b00, 0, 0, 0);
      for (int i = 0; i < 6; i++) cyc("thru", 1, 8'(8'h12 + i), 2'b00, 1, 0, 0);
      check("thru_tail_tog", 32'(tail_tog), 32'h1);
      check("thru_rd_data", 32'(rd_data), 32'h16);

      // 5: underflow and clear priority
      cyc("reset", 0, 8'h00, 2'b00, 0, 0, 1);
      cyc("under", 0, 8'h00, 2'b00, 1, 0, 0);
      check("under_flag", 32'(underflow), 32'h1);
      cyc("clr", 0, 8'h00, 2'b00, 0, 1, 0);
      check("clr_flag", 32'(underflow), 32'h0);
      cyc("clr_vs_set", 0, 8'h00, 2'b00, 1, 1, 0);
      check("clr_vs_set_flag", 32'(underflow), 32'h1);

      // 6: reset while partly filled
      cyc("reset", 0, 8'h00, 2'b00, 0, 0, 1);
      for (int i = 0; i < 3; i++) cyc("fill3", 1, 8'(8'h30 + i), 2'(i), 0, 0, 0);
      cyc("mid_rst", 1, 8'h77, 2'b11, 1, 0, 1);
      check("mid_rst_tail_ptr", 32'(tail_ptr), 32'h0);

      // Random traffic with occasional clears and resets
      for (int i = 0; i < 400; i++) begin
         cyc("rand", 1'($urandom_range(0, 99) < 55), 8'($urandom), 2'($urandom),
             1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 8),
             1'($urandom_range(0, 99) < 2));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/rcv_fifo_ptrs.md
Name: rcv_fifo_ptrs

Overview:
Storage and pointer-management stage of the receive FIFO.
- Holds a 4-entry circular buffer of received data bytes, each with a side-band status field.
- Maintains the write (head) and read (tail) pointers and their wrap toggle bits.
- Drives the pointer/toggle/side-band signals consumed by the downstream combinational full/empty/framing-error decode block.
- Data arrives from the serial receiver's byte-assembly stage and is drained by the bus-side read logic.

Parameters:
DATA_WIDTH, 8, width of each stored data word
SIDE_WIDTH, 2, width of per-entry side-band status (nonzero = framing fault on that byte)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
wr_en  input  1  write request from receiver stage
wr_data  input  DATA_WIDTH  byte to store
wr_side  input  SIDE_WIDTH  status for the byte being written
rd_en  input  1  pop request from read side
clr_err  input  1  clears sticky overflow/underflow flags
rd_data  output  DATA_WIDTH  entry at tail (first-word-fall-through)
head_ptr  output  2  write pointer
tail_ptr  output  2  read pointer
head_tog  output  1  flips each time head_ptr wraps 3->0
tail_tog  output  1  flips each time tail_ptr wraps 3->0
tail_side  output  SIDE_WIDTH  side-band of entry at tail
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset: synchronous, active-high, takes effect on the clock edge where rst=1.
  - Reset values: head_ptr=0, tail_ptr=0, head_tog=0, tail_tog=0, overflow=0, underflow=0.
  - Storage contents are don't-care after reset; they are never observable while empty.
  - Reset mid-operation discards all entries; the FIFO reads empty on the following cycle.
- Internal status, derived from registered state:
  - empty = (head_ptr==tail_ptr) && (head_tog==tail_tog).
  - full = (head_ptr==tail_ptr) && (head_tog!=tail_tog).
  - This must match the downstream decode exactly.
- Write acceptance: accepted iff wr_en && !full, using full as sampled before the edge.
  - On accept: mem[head_ptr] <= {wr_side, wr_data}; head_ptr <= head_ptr+1 (mod 4).
  - head_tog inverts when head_ptr goes 3->0.
- Read acceptance: accepted iff rd_en && !empty, using empty as sampled before the edge.
  - On accept: tail_ptr <= tail_ptr+1 (mod 4).
  - tail_tog inverts when tail_ptr goes 3->0.
- Simultaneous wr_en and rd_en, each evaluated independently against pre-edge status:
  - Neither full nor empty: both occur; occupancy unchanged.
  - Full: read occurs, write dropped, overflow set.
  - Empty: write occurs, read ignored, underflow set.
- No write-to-read bypass: a byte written in cycle N is first visible on rd_data in cycle N+1.
- Sticky flags:
  - overflow <= 1 on wr_en && full.
  - underflow <= 1 on rd_en && empty.
  - clr_err=1 clears both; a set event in the same cycle as clr_err wins (flag stays 1).
- rd_data = mem[tail_ptr][DATA_WIDTH-1:0] combinationally; forced to 0 when empty.
- tail_side = mem[tail_ptr][side field] combinationally; forced to 0 when empty, so the downstream block never reports a stale framing error.
- Latency: write-to-visible 1 cycle; pop-to-next-entry 1 cycle; no wait states.
- Pointer and toggle outputs are driven directly from registers (glitch-free for the decode stage).

Optional Feature:
Macro RCV_FIFO_COUNT_EN.
- Defined: adds output port count (3 bits), a registered occupancy 0..4.
  - Reset value 0.
  - +1 on accepted write only, -1 on accepted read only, unchanged on both or neither.
  - Bench checks count == 4 exactly when full, and count == 0 exactly when empty.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset then idle -> head_ptr=tail_ptr=0, both toggles 0, rd_data=0, tail_side=0, overflow=underflow=0.
2. Write 0xA1,0xB2,0xC3,0xD4 with side 0 -> head_ptr=0, head_tog=1, tail_ptr=0 (full); 5th write 0xE5 -> dropped, overflow=1, rd_data still 0xA1.
3. Write 0x55 with wr_side=2'b01 into empty FIFO -> next cycle tail_side=01, rd_data=0x55; pop -> tail_side=00, empty.
4. From 2 entries, assert wr_en+rd_en for 6 cycles with incrementing data -> occupancy stays 2, pointers wrap, tail_tog toggles at 3->0, data order preserved.
5. rd_en on empty FIFO -> tail_ptr unchanged, underflow=1; clr_err pulse -> underflow=0; clr_err coincident with a new underflow -> underflow stays 1.
6. Fill 3 entries, assert rst for one cycle -> next cycle all pointers and toggles 0, empty; with RCV_FIFO_COUNT_EN defined, count steps 0,1,2,3 during the fill and reads 0 after reset.
